// File: rtl/fpmul_share_ctrl_if.sv
// Request/response bundle between two issuing units and the shared FP multiplier controller.
// Valid/ready: a transfer happens on a rising clock edge where valid and ready are both high;
// the source holds valid and its payload stable until that edge, and the sink may raise ready at any time.
interface fpmul_share_ctrl_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic        rsp0_valid;
    logic        rsp0_ready;
    logic        rsp1_valid;
    logic        rsp1_ready;
    logic [31:0] rsp_data;

    modport master (
        output req0_valid, req0_a, req0_b,
        output req1_valid, req1_a, req1_b,
        output rsp0_ready, rsp1_ready,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp1_valid, rsp_data
    );

    modport slave (
        input  req0_valid, req0_a, req0_b,
        input  req1_valid, req1_a, req1_b,
        input  rsp0_ready, rsp1_ready,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp1_valid, rsp_data
    );
endinterface

// File: rtl/fpmul_share_ctrl.sv
// Round-robin controller sharing one combinational binary32 multiplier between two requesters,
// with a multicycle hold window before the product is captured.

module fpmultiplier (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] p
);
    logic               sign;
    logic [7:0]         ea;
    logic [7:0]         eb;
    logic [7:0]         ea_eff;
    logic [7:0]         eb_eff;
    logic [22:0]        fa;
    logic [22:0]        fb;
    logic               a_zero;
    logic               b_zero;
    logic               a_inf;
    logic               b_inf;
    logic               a_nan;
    logic               b_nan;
    logic [23:0]        ma;
    logic [23:0]        mb;
    logic [47:0]        prod;
    logic [47:0]        norm;
    logic [46:0]        shifted;
    logic [5:0]         lead;
    logic signed [10:0] exp_sum;
    logic signed [10:0] sh_amt;
    logic               lost;
    logic               guard;
    logic               sticky;
    logic               round_up;
    logic [7:0]         exp_field;
    logic [30:0]        mag;

    assign sign   = a[31] ^ b[31];
    assign ea     = a[30:23];
    assign eb     = b[30:23];
    assign fa     = a[22:0];
    assign fb     = b[22:0];
    assign a_zero = (ea == 8'd0) && (fa == 23'd0);
    assign b_zero = (eb == 8'd0) && (fb == 23'd0);
    assign a_inf  = (ea == 8'hFF) && (fa == 23'd0);
    assign b_inf  = (eb == 8'hFF) && (fb == 23'd0);
    assign a_nan  = (ea == 8'hFF) && (fa != 23'd0);
    assign b_nan  = (eb == 8'hFF) && (fb != 23'd0);
    // Subnormals carry no hidden bit but share the exponent of the smallest normal.
    assign ea_eff = (ea == 8'd0) ? 8'd1 : ea;
    assign eb_eff = (eb == 8'd0) ? 8'd1 : eb;
    assign ma     = {ea != 8'd0, fa};
    assign mb     = {eb != 8'd0, fb};
    assign prod   = ma * mb;

    always_comb begin
        lead = 6'd0;
        for (int i = 0; i < 48; i++) begin
            if (prod[i]) lead = 6'(i);
        end
    end

    // Round-to-nearest-even; adding the round bit to {exponent, fraction} carries naturally
    // into the exponent, covering subnormal-to-normal and normal-to-infinity.
    always_comb begin
        exp_sum   = $signed({3'b000, ea_eff}) + $signed({3'b000, eb_eff})
                  + $signed({5'b00000, lead}) - 11'sd173;
        norm      = prod << (6'd47 - lead);
        sh_amt    = 11'sd1 - exp_sum;
        shifted   = norm[46:0];
        lost      = 1'b0;
        exp_field = exp_sum[7:0];
        if (exp_sum < 11'sd1) begin
            exp_field = 8'd0;
            if (sh_amt > 11'sd47) begin
                shifted = 47'd0;
                lost    = |norm;
            end else begin
                shifted = 47'(norm >> sh_amt[5:0]);
                lost    = |(norm & ((48'd1 << sh_amt[5:0]) - 48'd1));
            end
        end
        guard    = shifted[23];
        sticky   = (|shifted[22:0]) | lost;
        round_up = guard & (sticky | shifted[24]);
        mag      = {exp_field, shifted[46:24]} + {30'd0, round_up};

        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            p = 32'h7FC0_0000;
        end else if (a_inf || b_inf || (exp_sum > 11'sd254)) begin
            p = {sign, 8'hFF, 23'd0};
        end else if (a_zero || b_zero) begin
            p = {sign, 31'd0};
        end else begin
            p = {sign, mag};
        end
    end
endmodule

module fpmul_share_ctrl #(
    parameter int MUL_LATENCY = 1,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    fpmul_share_ctrl_if.slave bus,
    output logic              busy,
    output logic              grant_id,
    output logic [CNT_W-1:0]  op_count,
    output logic [1:0]        dbg_state
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] LAT = 4'(MUL_LATENCY);

    state_t      state;
    logic        last_grant;
    logic [3:0]  wait_cnt;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] product;
    logic [31:0] rsp_data_q;
    logic        rsp0_valid_q;
    logic        rsp1_valid_q;
    logic        grant0;
    logic        grant1;
    logic        accept0;
    logic        accept1;
    logic        rsp_hs;

    fpmultiplier u_mul (
        .a (op_a),
        .b (op_b),
        .p (product)
    );

    // On a tie the requester that did not win last time gets the slot.
    assign grant0  = bus.req0_valid & (~bus.req1_valid | last_grant);
    assign grant1  = bus.req1_valid & (~bus.req0_valid | ~last_grant);
    assign accept0 = bus.req0_ready;
    assign accept1 = bus.req1_ready;

    assign bus.req0_ready = rst_n & (state == IDLE) & grant0;
    assign bus.req1_ready = rst_n & (state == IDLE) & grant1;
    assign bus.rsp0_valid = rsp0_valid_q;
    assign bus.rsp1_valid = rsp1_valid_q;
    assign bus.rsp_data   = rsp_data_q;

    assign rsp_hs    = grant_id ? (rsp1_valid_q & bus.rsp1_ready)
                                : (rsp0_valid_q & bus.rsp0_ready);
    assign busy      = (state != IDLE);
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            grant_id     <= 1'b0;
            wait_cnt     <= 4'd0;
            op_a         <= 32'd0;
            op_b         <= 32'd0;
            rsp_data_q   <= 32'd0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            op_count     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept0 || accept1) begin
                        op_a       <= accept1 ? bus.req1_a : bus.req0_a;
                        op_b       <= accept1 ? bus.req1_b : bus.req0_b;
                        last_grant <= accept1;
                        grant_id   <= accept1;
                        wait_cnt   <= LAT;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    // Operands stay frozen on the multiplier for the whole window.
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1) begin
                        rsp_data_q   <= product;
                        rsp0_valid_q <= ~grant_id;
                        rsp1_valid_q <= grant_id;
                        state        <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_hs) begin
                        rsp0_valid_q <= 1'b0;
                        rsp1_valid_q <= 1'b0;
                        op_count     <= op_count + {{(CNT_W-1){1'b0}}, 1'b1};
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.req0_ready && bus.req1_ready));
    a_rsp_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (state == RESP && !rsp_hs) |=> $stable(rsp_data_q));
endmodule
